// File: rtl/grf_pkg.sv
// Shared types and helpers for global_register_file_mp and its read ports.
// Optional build macro GRF_RD_BYPASS_EN enables same-cycle write-through forwarding.
package grf_pkg;

  localparam int   GRF_DATA_WIDTH     = 16;
  localparam int   GRF_NUM_REGS       = 16;
  localparam int   GRF_NUM_READ_PORTS = 2;
  localparam logic GRF_RST_FILL       = 1'b0;

  typedef enum logic {
    GRF_IDLE,
    GRF_CLEAR
  } grf_state_e;

  // LSB offset of a port's slice inside a flattened per-port bus.
  function automatic int grf_slice_lo(int port, int width);
    return port * width;
  endfunction

  function automatic logic grf_in_range(int unsigned addr, int unsigned num_regs);
    return addr < num_regs;
  endfunction

endpackage

// File: rtl/grf_read_port.sv
// One combinational read port: range check, register/flag lookup and,
// when GRF_RD_BYPASS_EN is defined, forwarding of the accepted write.
module grf_read_port
  import grf_pkg::*;
#(
  parameter int DATA_WIDTH = GRF_DATA_WIDTH,
  parameter int NUM_REGS   = GRF_NUM_REGS,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] regs [NUM_REGS],
  input  logic [NUM_REGS-1:0]   busy,
  input  logic [NUM_REGS-1:0]   written,
`ifdef GRF_RD_BYPASS_EN
  input  logic                  byp_en,
  input  logic [ADDR_WIDTH-1:0] byp_addr,
  input  logic [DATA_WIDTH-1:0] byp_data,
`endif
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_busy,
  output logic                  rd_written
);

  logic addr_ok;

  assign addr_ok = grf_in_range(32'(rd_addr), NUM_REGS);

  // NOTE: every output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    rd_data    = '0;
    rd_busy    = 1'b0;
    rd_written = 1'b0;
    if (addr_ok) begin
      rd_data    = regs[rd_addr];
      rd_busy    = busy[rd_addr];
      rd_written = written[rd_addr];
    end
`ifdef GRF_RD_BYPASS_EN
    // byp_en is only raised for in-range writes outside a clear; busy stays registered.
    if (byp_en && (byp_addr == rd_addr)) begin
      rd_data    = byp_data;
      rd_written = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/global_register_file_mp.sv
// Multi-port global register file: two arbitrated write sources, busy scoreboard,
// sequenced bulk clear. Optional macro GRF_RD_BYPASS_EN adds read forwarding.
module global_register_file_mp
  import grf_pkg::*;
#(
  parameter  int DATA_WIDTH     = GRF_DATA_WIDTH,
  parameter  int NUM_REGS       = GRF_NUM_REGS,
  parameter  int NUM_READ_PORTS = GRF_NUM_READ_PORTS,
  localparam int ADDR_WIDTH     = $clog2(NUM_REGS)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 clear_req,
  output logic                                 clear_busy,
  input  logic                                 wr_a_en,
  input  logic [ADDR_WIDTH-1:0]                wr_a_addr,
  input  logic [DATA_WIDTH-1:0]                wr_a_data,
  input  logic                                 wr_b_en,
  input  logic [ADDR_WIDTH-1:0]                wr_b_addr,
  input  logic [DATA_WIDTH-1:0]                wr_b_data,
  output logic                                 wr_b_stall,
  input  logic                                 rsv_en,
  input  logic [ADDR_WIDTH-1:0]                rsv_addr,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_READ_PORTS-1:0]            rd_busy,
  output logic [NUM_READ_PORTS-1:0]            rd_written
);

  localparam logic [DATA_WIDTH-1:0] RST_DATA = {DATA_WIDTH{GRF_RST_FILL}};
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic [NUM_REGS-1:0]   written_q, written_d;
  grf_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  logic                  wr_ok;
  logic                  rsv_ok;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  assign clear_busy = (state_q == GRF_CLEAR);
  assign wr_b_stall = wr_b_en & (wr_a_en | clear_busy);

  // Source A always wins the single array write port.
  assign wr_addr = wr_a_en ? wr_a_addr : wr_b_addr;
  assign wr_data = wr_a_en ? wr_a_data : wr_b_data;
  assign wr_ok   = ~clear_busy & (wr_a_en | wr_b_en) & grf_in_range(32'(wr_addr), NUM_REGS);
  assign rsv_ok  = rsv_en & ~clear_busy & grf_in_range(32'(rsv_addr), NUM_REGS);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    regs_d    = regs_q;
    busy_d    = busy_q;
    written_d = written_q;
    case (state_q)
      GRF_IDLE: begin
        if (wr_ok) begin
          regs_d[wr_addr]    = wr_data;
          written_d[wr_addr] = 1'b1;
          busy_d[wr_addr]    = 1'b0;
        end
        // Applied after the write so a same-cycle reserve keeps the register busy.
        if (rsv_ok) busy_d[rsv_addr] = 1'b1;
        if (clear_req) begin
          state_d = GRF_CLEAR;
          cnt_d   = '0;
        end
      end
      GRF_CLEAR: begin
        regs_d[cnt_q]    = RST_DATA;
        busy_d[cnt_q]    = 1'b0;
        written_d[cnt_q] = 1'b0;
        if (cnt_q == LAST_IDX) begin
          state_d = GRF_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: state_d = GRF_IDLE;
    endcase
  end

  // NOTE: the register array sits in the reset domain because reset must zero every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= GRF_IDLE;
      cnt_q     <= '0;
      busy_q    <= '0;
      written_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RST_DATA;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      written_q <= written_d;
      regs_q    <= regs_d;
    end
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
    localparam int ALO = grf_slice_lo(p, ADDR_WIDTH);
    localparam int DLO = grf_slice_lo(p, DATA_WIDTH);

    grf_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_port (
      .rd_addr    (rd_addr[ALO +: ADDR_WIDTH]),
      .regs       (regs_q),
      .busy       (busy_q),
      .written    (written_q),
`ifdef GRF_RD_BYPASS_EN
      .byp_en     (wr_ok),
      .byp_addr   (wr_addr),
      .byp_data   (wr_data),
`endif
      .rd_data    (rd_data[DLO +: DATA_WIDTH]),
      .rd_busy    (rd_busy[p]),
      .rd_written (rd_written[p])
    );
  end

endmodule

// File: tb/tb_global_register_file_mp.sv
// Scoreboard bench for global_register_file_mp: a 16-entry and a 12-entry instance share
// stimulus; a behavioural model queues expected outputs, a monitor compares at negedge.
module tb_global_register_file_mp;

  localparam int DW = 16;
  localparam int NP = 2;
  localparam int AW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            clear_req, wr_a_en, wr_b_en, rsv_en;
  logic [AW-1:0]   wr_a_addr, wr_b_addr, rsv_addr;
  logic [DW-1:0]   wr_a_data, wr_b_data;
  logic [NP*AW-1:0] rd_addr;

  logic             clear_busy0, wr_b_stall0, clear_busy1, wr_b_stall1;
  logic [NP*DW-1:0] rd_data0, rd_data1;
  logic [NP-1:0]    rd_busy0, rd_written0, rd_busy1, rd_written1;

  global_register_file_mp #(.DATA_WIDTH(DW), .NUM_REGS(16), .NUM_READ_PORTS(NP)) dut0 (
    .clk(clk), .reset(reset), .clear_req(clear_req), .clear_busy(clear_busy0),
    .wr_a_en(wr_a_en), .wr_a_addr(wr_a_addr), .wr_a_data(wr_a_data),
    .wr_b_en(wr_b_en), .wr_b_addr(wr_b_addr), .wr_b_data(wr_b_data), .wr_b_stall(wr_b_stall0),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_addr(rd_addr),
    .rd_data(rd_data0), .rd_busy(rd_busy0), .rd_written(rd_written0)
  );

  global_register_file_mp #(.DATA_WIDTH(DW), .NUM_REGS(12), .NUM_READ_PORTS(NP)) dut1 (
    .clk(clk), .reset(reset), .clear_req(clear_req), .clear_busy(clear_busy1),
    .wr_a_en(wr_a_en), .wr_a_addr(wr_a_addr), .wr_a_data(wr_a_data),
    .wr_b_en(wr_b_en), .wr_b_addr(wr_b_addr), .wr_b_data(wr_b_data), .wr_b_stall(wr_b_stall1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_busy(rd_busy1), .rd_written(rd_written1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             stall;
    logic             cbusy;
    logic [NP*DW-1:0] d;
    logic [NP-1:0]    b;
    logic [NP-1:0]    w;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   total = 0;
  int   bad   = 0;

  // Reference state: plain arrays plus a "clear in progress" flag and index.
  logic [DW-1:0] m_mem  [2][16];
  bit            m_busy [2][16];
  bit            m_wr   [2][16];
  bit            m_clr  [2];
  int            m_idx  [2];

  function automatic int nregs(int i);
    return (i == 0) ? 16 : 12;
  endfunction

  task automatic check(string name, int inst, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 16; r++) begin
        m_mem[i][r]  = '0;
        m_busy[i][r] = 1'b0;
        m_wr[i][r]   = 1'b0;
      end
      m_clr[i] = 1'b0;
      m_idx[i] = 0;
    end
  endtask

  // Predict this cycle's outputs, queue them, advance the model, then move to the next cycle.
  task automatic step();
    for (int i = 0; i < 2; i++) begin
      exp_t          e;
      bit            wok;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      int            n;
      int            a;
      n       = nregs(i);
      e       = '0;
      e.cbusy = m_clr[i];
      e.stall = wr_b_en && (wr_a_en || m_clr[i]);
      wa      = wr_a_en ? wr_a_addr : wr_b_addr;
      wd      = wr_a_en ? wr_a_data : wr_b_data;
      wok     = !m_clr[i] && (wr_a_en || wr_b_en) && (int'(wa) < n);
      for (int p = 0; p < NP; p++) begin
        a = int'(rd_addr[p*AW +: AW]);
        if (a < n) begin
          e.d[p*DW +: DW] = m_mem[i][a];
          e.b[p]          = m_busy[i][a];
          e.w[p]          = m_wr[i][a];
        end
`ifdef GRF_RD_BYPASS_EN
        if (wok && (int'(wa) == a)) begin
          e.d[p*DW +: DW] = wd;
          e.w[p]          = 1'b1;
        end
`endif
      end
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
      if (!reset) begin
        if (m_clr[i]) begin
          m_mem[i][m_idx[i]]  = '0;
          m_busy[i][m_idx[i]] = 1'b0;
          m_wr[i][m_idx[i]]   = 1'b0;
          m_idx[i]++;
          if (m_idx[i] == n) m_clr[i] = 1'b0;
        end else begin
          if (wok) begin
            m_mem[i][wa]  = wd;
            m_wr[i][wa]   = 1'b1;
            m_busy[i][wa] = 1'b0;
          end
          if (rsv_en && (int'(rsv_addr) < n)) m_busy[i][rsv_addr] = 1'b1;
          if (clear_req) begin
            m_clr[i] = 1'b1;
            m_idx[i] = 0;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear_req = 1'b0;
    wr_a_en   = 1'b0;
    wr_b_en   = 1'b0;
    rsv_en    = 1'b0;
    wr_a_addr = '0;
    wr_b_addr = '0;
    rsv_addr  = '0;
    wr_a_data = '0;
    wr_b_data = '0;
    rd_addr   = '0;
  endtask

  task automatic rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    model_reset();
    step();
    reset = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        check("wr_b_stall", 0, 64'(wr_b_stall0), 64'(e0.stall));
        check("clear_busy", 0, 64'(clear_busy0), 64'(e0.cbusy));
        check("rd_data",    0, 64'(rd_data0),    64'(e0.d));
        check("rd_busy",    0, 64'(rd_busy0),    64'(e0.b));
        check("rd_written", 0, 64'(rd_written0), 64'(e0.w));
      end
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        check("wr_b_stall", 1, 64'(wr_b_stall1), 64'(e1.stall));
        check("clear_busy", 1, 64'(clear_busy1), 64'(e1.cbusy));
        check("rd_data",    1, 64'(rd_data1),    64'(e1.d));
        check("rd_busy",    1, 64'(rd_busy1),    64'(e1.b));
        check("rd_written", 1, 64'(rd_written1), 64'(e1.w));
      end
    end
  end

  initial begin
    idle();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    step();
    step();
    reset = 1'b0;

    // Write A then read back.
    idle(); wr_a_en = 1; wr_a_addr = 3; wr_a_data = 16'h1234; rd(3, 3); step();
    idle(); rd(3, 0); step();

    // Simultaneous A and B: B stalls, then is held one more cycle.
    idle(); wr_a_en = 1; wr_a_addr = 5; wr_a_data = 16'hAAAA;
    wr_b_en = 1; wr_b_addr = 6; wr_b_data = 16'hBBBB; rd(5, 6); step();
    wr_a_en = 0; step();
    idle(); rd(5, 6); step();

    // Reserve, clear by writeback, then reserve and write in the same cycle.
    idle(); rsv_en = 1; rsv_addr = 7; rd(7, 7); step();
    idle(); rd(7, 7); step();
    idle(); wr_b_en = 1; wr_b_addr = 7; wr_b_data = 16'h0F0F; rd(7, 7); step();
    idle(); rd(7, 7); step();
    idle(); rsv_en = 1; rsv_addr = 7; wr_a_en = 1; wr_a_addr = 7; wr_a_data = 16'h1111; step();
    idle(); rd(7, 7); step();

    // Out-of-range for the 12-entry instance.
    idle(); wr_a_en = 1; wr_a_addr = 13; wr_a_data = 16'hDEAD; rsv_en = 1; rsv_addr = 14; step();
    idle(); rd(13, 14); step();

    // Fill, then full clear with a B write held during the clear.
    for (int r = 0; r < 16; r++) begin
      idle(); wr_a_en = 1; wr_a_addr = AW'(r); wr_a_data = DW'(16'h100 + r); rd(r, 15); step();
    end
    idle(); clear_req = 1; rd(0, 15); step();
    for (int c = 0; c < 20; c++) begin
      idle(); wr_b_en = 1; wr_b_addr = 4; wr_b_data = 16'h4444;
      clear_req = (c == 3); rsv_en = 1; rsv_addr = 9; rd(0, 15); step();
    end
    for (int r = 0; r < 16; r++) begin
      idle(); rd(r, 15 - r); step();
    end

    // Reset in the middle of a clear, then a fresh clear.
    for (int r = 0; r < 16; r++) begin
      idle(); wr_a_en = 1; wr_a_addr = AW'(r); wr_a_data = DW'($urandom); step();
    end
    idle(); clear_req = 1; step();
    for (int c = 0; c < 8; c++) begin
      idle(); rd(c, 15); step();
    end
    do_reset();
    idle(); wr_a_en = 1; wr_a_addr = 9; wr_a_data = 16'h9999; rd(8, 15); step();
    idle(); clear_req = 1; rd(9, 0); step();
    for (int c = 0; c < 18; c++) begin
      idle(); rd(9, 0); step();
    end

    // Same-cycle write and read of one address.
    idle(); wr_a_en = 1; wr_a_addr = 2; wr_a_data = 16'h5555; rd(0, 2); step();
    idle(); rd(0, 2); step();

    // Randomized traffic.
    for (int k = 0; k < 800; k++) begin
      idle();
      wr_a_en   = ($urandom_range(0, 3) == 0);
      wr_a_addr = AW'($urandom_range(0, 15));
      wr_a_data = DW'($urandom);
      wr_b_en   = ($urandom_range(0, 1) == 0);
      wr_b_addr = AW'($urandom_range(0, 15));
      wr_b_data = DW'($urandom);
      rsv_en    = ($urandom_range(0, 4) == 0);
      rsv_addr  = AW'($urandom_range(0, 15));
      clear_req = ($urandom_range(0, 59) == 0);
      rd_addr   = (NP*AW)'($urandom);
      if ($urandom_range(0, 2) == 0) rd_addr[AW +: AW] = wr_a_en ? wr_a_addr : wr_b_addr;
      if ($urandom_range(0, 249) == 0) do_reset();
      else                             step();
    end

    idle();
    step();
    @(negedge clk);
    #1;
    check("queue_drain", 0, 64'(q0.size() + q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/global_register_file_mp.md
Name: global_register_file_mp

Overview:
Parametrised multi-port successor to the global helper register file.
- Two write sources (controller immediate loads and compute-unit writeback) arbitrated onto a single array write per cycle.
- NUM_READ_PORTS independent read ports, a per-register busy scoreboard for outstanding loads, and a sequenced bulk-clear engine.
- Sits beside the warp scheduler; read ports feed operand collection for every lane.

Parameters:
DATA_WIDTH, 16, bits per register
NUM_REGS, 16, register count (>=2; need not be a power of two)
NUM_READ_PORTS, 2, independent combinational read ports (>=1)
ADDR_WIDTH (localparam), $clog2(NUM_REGS), address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
clear_req  in  1  one-cycle pulse, start bulk clear
clear_busy  out  1  high while the clear sequence runs
wr_a_en  in  1  controller immediate write (priority source)
wr_a_addr  in  ADDR_WIDTH  write A address
wr_a_data  in  DATA_WIDTH  write A data
wr_b_en  in  1  writeback write
wr_b_addr  in  ADDR_WIDTH  write B address
wr_b_data  in  DATA_WIDTH  write B data
wr_b_stall  out  1  write B not accepted this cycle; source holds
rsv_en  in  1  reserve register (mark busy for pending load)
rsv_addr  in  ADDR_WIDTH  reserve address
rd_addr  in  NUM_READ_PORTS*ADDR_WIDTH  flattened read addresses, port 0 in LSBs
rd_data  out  NUM_READ_PORTS*DATA_WIDTH  flattened read data
rd_busy  out  NUM_READ_PORTS  register at port's address is reserved
rd_written  out  NUM_READ_PORTS  register written since last reset/clear

Behaviour:
- Reset (async): all registers 0, busy[] 0, written[] 0, FSM IDLE, clear counter 0.
  - Outputs after reset: clear_busy=0, wr_b_stall=0, rd_data=0, rd_busy=0, rd_written=0.
  - Reset mid-clear aborts the clear and takes the reset state.
- Writes:
  - At most one array write per clk.
  - Accepted write updates the register, sets written[addr]=1 and clears busy[addr] on the next edge.
- Arbitration:
  - wr_a_en=1 wins. wr_b_stall = wr_b_en & (wr_a_en | clear_busy), combinational.
  - Stalled B writes are dropped; the source must hold them.
  - wr_a during clear_busy is ignored silently; the controller must not issue it.
- Reserve:
  - rsv_en sets busy[rsv_addr] at the next edge.
  - If an accepted write targets the same address in the same cycle, reserve wins: busy=1, data and written still update.
  - rsv_en during clear_busy is ignored.
- Reads:
  - Combinational from the array; registered writes are visible from the cycle after the write edge.
  - rd_busy and rd_written are combinational lookups.
- Out-of-range addresses (>= NUM_REGS):
  - Writes and reserves are ignored.
  - Reads return data 0, busy 0, written 0.
- Clear FSM:
  - IDLE: clear_req=1 → CLEAR with counter=0. clear_req while in CLEAR is ignored.
  - CLEAR: each cycle zeroes reg[counter] and clears busy[counter] and written[counter], then increments counter. At counter==NUM_REGS-1 it zeroes the last entry and returns to IDLE.
  - Clear takes exactly NUM_REGS cycles; clear_busy=1 throughout CLEAR.
  - Reads during CLEAR return the current, partially cleared contents.

Optional Feature:
GRF_RD_BYPASS_EN.
- Defined: if an accepted write's address equals a read port's address in the same cycle, that port's rd_data returns the write data and rd_written=1 combinationally (write-through forwarding).
  - rd_busy is still the registered value.
  - No bypass during CLEAR.
- Undefined: reads return the pre-write value until the next cycle.

Decomposition:
- Package grf_pkg: default widths, reset data constant, clear-FSM state typedef (GRF_IDLE, GRF_CLEAR), and a function flattening or extracting per-port slices.
- One natural sub-module, grf_read_port: address range check, array/flag lookup and optional bypass mux. Instantiated NUM_READ_PORTS times in a generate loop.

Test Plan:
1. Reset, then write A (addr 3, 0x1234); next cycle read port 0 addr 3 → rd_data 0x1234, rd_written=1, rd_busy=0.
2. Same cycle wr_a (addr 5, 0xAAAA) and wr_b (addr 6, 0xBBBB) → wr_b_stall=1, reg5=0xAAAA; B held one cycle → reg6=0xBBBB, stall 0.
3. rsv_en addr 7 → rd_busy=1 next cycle. Then wr_b addr 7 with 0x0F0F → busy=0, data 0x0F0F. Repeat with rsv and write to addr 7 in the same cycle → busy stays 1, data updated.
4. Fill all 16 registers, pulse clear_req → clear_busy high exactly 16 cycles. Mid-clear, reg0 reads 0 and reg15 keeps its value; after the clear, all reads return 0/written 0. wr_b during clear → stall.
5. Assert reset at clear cycle 8 → clear_busy=0 immediately, all registers 0. A new clear_req restarts from counter 0.
6. With GRF_RD_BYPASS_EN: write addr 2 (0x5555) while port 1 reads addr 2 → same-cycle rd_data 0x5555. Without the macro → old value (0), then 0x5555 next cycle.
